dbp_unpack: RTL

DBP_UNPACK -- requirements
Module: dbp_unpack

---
 rtl/dbp_unpack.sv | 105 ++++++++++
 1 files changed

// File: rtl/dbp_unpack.sv
// Delta-bitplane unpacker: DBX->DBP, plane transpose to deltas,
// then prefix-sum emission of one reconstructed word per cycle.
package ebpc_pkg;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BLOCK_SIZE = 8;
  localparam int unsigned CNT_W      =
    (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  typedef struct packed {
    logic [DATA_W-1:0]               base;
    logic [DATA_W:0][BLOCK_SIZE-2:0] dbp;
    logic                            flush;
  } dbp_block_t;
endpackage

module dbp_unpack
  import ebpc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  dbp_block_t        data_i,
  input  logic              vld_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              vld_o,
  input  logic              rdy_i,
  input  logic              clr_i
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  state_e                            state_q;
  logic [DATA_W-1:0]                 acc_q;
  logic [BLOCK_SIZE-2:0][DATA_W-1:0] dlt_q;
  logic [BLOCK_SIZE-2:0][DATA_W-1:0] dlt_d;
  logic [CNT_W-1:0]                  cnt_q;
  logic                              vld_q;
  logic                              last_q;
  logic [BLOCK_SIZE-2:0]             run;
  logic                              load;
  logic                              unused_flush;

  assign unused_flush = data_i.flush;

  // Running XOR from the top plane down yields each DBP plane;
  // the delta sign bit (plane DATA_W) is dropped as it vanishes mod 2^W.
  always_comb begin
    dlt_d = '0;
    run   = data_i.dbp[DATA_W];
    for (int i = DATA_W - 1; i >= 0; i--) begin
      run = run ^ data_i.dbp[i];
      for (int j = 0; j < BLOCK_SIZE - 1; j++) begin
        dlt_d[j][i] = run[BLOCK_SIZE-2-j];
      end
    end
  end

  assign rdy_o = ~clr_i
               & ((state_q == IDLE) | (last_q & rdy_i));
  assign load  = vld_i & rdy_o;

  assign data_o = acc_q;
  assign last_o = last_q;
  assign vld_o  = vld_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      dlt_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (clr_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      dlt_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (load) begin
      state_q <= EMIT;
      acc_q   <= data_i.base;
      dlt_q   <= dlt_d;
      cnt_q   <= '0;
      vld_q   <= 1'b1;
      last_q  <= (BLOCK_SIZE == 1);
    end else if (state_q == EMIT && rdy_i) begin
      if (last_q) begin
        state_q <= IDLE;
        vld_q   <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        acc_q  <= acc_q + dlt_q[cnt_q];
        cnt_q  <= cnt_q + CNT_W'(1);
        last_q <= (cnt_q == CNT_W'(BLOCK_SIZE - 2));
      end
    end
  end

endmodule
